// File: rtl/tpm_cmd_parser.sv
// tpm_cmd_parser
//   Parses the header of a big-endian TPM 2.0 command byte stream coming from
//   the SPI I/O FIFO: tag, commandSize, commandCode and up to three handles.
//   The remaining parameter bytes are counted and dropped. One result (fields
//   or a TPM response code) is presented and held until acknowledged.
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   in_valid/in_data/     byte stream in; in_last marks the final host byte;
//   in_last/in_ready      a byte moves when in_valid && in_ready
//   num_handles           handle count for cmd_code, sampled one cycle after byte 9
//   cmd_valid/cmd_ack     result handshake, held until ack
//   cmd_error/cmd_rc      error flag and TPM response code (0 = OK)
//   cmd_tag/cmd_size/     parsed header fields
//   cmd_code
//   handle_count,         handle area (unused handles read 0)
//   handle0..2
//   param_bytes           size - 10 - 4*handle_count
module tpm_cmd_parser #(
  parameter int unsigned MAX_CMD_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [1:0]  num_handles,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic        cmd_error,
  output logic [31:0] cmd_rc,
  output logic [15:0] cmd_tag,
  output logic [31:0] cmd_size,
  output logic [31:0] cmd_code,
  output logic [1:0]  handle_count,
  output logic [31:0] handle0,
  output logic [31:0] handle1,
  output logic [31:0] handle2,
  output logic [15:0] param_bytes
);

  localparam logic [31:0] RC_BAD_TAG  = 32'h0000_001E;
  localparam logic [31:0] RC_CMD_SIZE = 32'h0000_0142;
  localparam logic [31:0] MAX_SIZE    = MAX_CMD_SIZE;

  typedef enum logic [2:0] {S_HDR, S_LOOKUP, S_HANDLES, S_BODY, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] rc_q, rc_d;
  logic [15:0] tag_q, tag_d;
  logic [31:0] size_q, size_d, code_q, code_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [31:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  logic [15:0] param_q, param_d;
  logic        end_seen_q, end_seen_d;
  logic        in_ready_q, in_ready_d, cmd_valid_q, cmd_valid_d, cmd_error_q, cmd_error_d;

  logic        accept, at_end;
  logic [15:0] idx_inc, hdl_end_idx;
  logic [31:0] hdl_need;

  // Only the first error of a command is reported.
  function automatic logic [31:0] keep_first(input logic [31:0] cur, input logic [31:0] nw);
    return (cur != 32'd0) ? cur : nw;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rc_d        = rc_q;
    tag_d       = tag_q;
    size_d      = size_q;
    code_d      = code_q;
    hcnt_d      = hcnt_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    param_d     = param_q;
    end_seen_d  = end_seen_q;

    accept      = in_valid && in_ready_q;
    idx_inc     = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
    at_end      = ({16'd0, idx_q} == size_q - 32'd1);
    hdl_need    = 32'd10 + {28'd0, num_handles, 2'b00};
    hdl_end_idx = 16'd9 + {12'd0, hcnt_q, 2'b00};

    case (state_q)
      S_HDR: if (accept) begin
        idx_d = idx_inc;
        if (idx_q == 16'd0) begin
          hcnt_d  = 2'd0;
          h0_d    = 32'd0;
          h1_d    = 32'd0;
          h2_d    = 32'd0;
          param_d = 16'd0;
        end
        if (idx_q < 16'd2)      tag_d  = {tag_q[7:0], in_data};
        else if (idx_q < 16'd6) size_d = {size_q[23:0], in_data};
        else                    code_d = {code_q[23:0], in_data};
        if (idx_q == 16'd1 && tag_d != 16'h8001 && tag_d != 16'h8002)
          rc_d = keep_first(rc_d, RC_BAD_TAG);
        if (idx_q == 16'd5 && (size_d < 32'd10 || size_d > MAX_SIZE))
          rc_d = keep_first(rc_d, RC_CMD_SIZE);
        if (idx_q == 16'd9) begin
          // A 10-byte command can legally end here; LOOKUP still runs so the
          // handle count is checked, and end_seen sends it straight to DONE.
          if (rc_d != 32'd0) begin
            state_d = in_last ? S_DONE : S_DRAIN;
          end else if (in_last && size_q != 32'd10) begin
            rc_d    = RC_CMD_SIZE;
            state_d = S_DONE;
          end else if (!in_last && size_q == 32'd10) begin
            rc_d    = RC_CMD_SIZE;
            state_d = S_DRAIN;
          end else begin
            end_seen_d = in_last;
            state_d    = S_LOOKUP;
          end
        end else if (in_last) begin
          rc_d    = keep_first(rc_d, RC_CMD_SIZE);
          state_d = S_DONE;
        end
      end

      S_LOOKUP: begin
        hcnt_d = num_handles;
        if (size_q < hdl_need) begin
          rc_d    = keep_first(rc_d, RC_CMD_SIZE);
          state_d = end_seen_q ? S_DONE : S_DRAIN;
        end else begin
          param_d = 16'(size_q - hdl_need);
          if (end_seen_q)                 state_d = S_DONE;
          else if (num_handles != 2'd0)   state_d = S_HANDLES;
          else                            state_d = S_BODY;
        end
      end

      S_HANDLES: if (accept) begin
        idx_d = idx_inc;
        if (idx_q < 16'd14)      h0_d = {h0_q[23:0], in_data};
        else if (idx_q < 16'd18) h1_d = {h1_q[23:0], in_data};
        else                     h2_d = {h2_q[23:0], in_data};
        if (at_end) begin
          if (in_last) state_d = S_DONE;
          else begin
            rc_d    = keep_first(rc_d, RC_CMD_SIZE);
            state_d = S_DRAIN;
          end
        end else if (in_last) begin
          rc_d    = keep_first(rc_d, RC_CMD_SIZE);
          state_d = S_DONE;
        end else if (idx_q == hdl_end_idx) begin
          state_d = S_BODY;
        end
      end

      S_BODY: if (accept) begin
        idx_d = idx_inc;
        if (at_end) begin
          if (in_last) state_d = S_DONE;
          else begin
            rc_d    = keep_first(rc_d, RC_CMD_SIZE);
            state_d = S_DRAIN;
          end
        end else if (in_last) begin
          rc_d    = keep_first(rc_d, RC_CMD_SIZE);
          state_d = S_DONE;
        end
      end

      S_DRAIN: if (accept) begin
        idx_d = idx_inc;
        if (in_last) state_d = S_DONE;
      end

      S_DONE: if (cmd_ack) begin
        state_d    = S_HDR;
        rc_d       = 32'd0;
        idx_d      = 16'd0;
        end_seen_d = 1'b0;
      end

      default: state_d = S_HDR;
    endcase

    in_ready_d  = (state_d == S_HDR) || (state_d == S_HANDLES) ||
                  (state_d == S_BODY) || (state_d == S_DRAIN);
    cmd_valid_d = (state_d == S_DONE);
    cmd_error_d = (state_d == S_DONE) && (rc_d != 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HDR;
      idx_q       <= 16'd0;
      rc_q        <= 32'd0;
      tag_q       <= 16'd0;
      size_q      <= 32'd0;
      code_q      <= 32'd0;
      hcnt_q      <= 2'd0;
      h0_q        <= 32'd0;
      h1_q        <= 32'd0;
      h2_q        <= 32'd0;
      param_q     <= 16'd0;
      end_seen_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rc_q        <= rc_d;
      tag_q       <= tag_d;
      size_q      <= size_d;
      code_q      <= code_d;
      hcnt_q      <= hcnt_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      param_q     <= param_d;
      end_seen_q  <= end_seen_d;
      in_ready_q  <= in_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_error    = cmd_error_q;
  assign cmd_rc       = rc_q;
  assign cmd_tag      = tag_q;
  assign cmd_size     = size_q;
  assign cmd_code     = code_q;
  assign handle_count = hcnt_q;
  assign handle0      = h0_q;
  assign handle1      = h1_q;
  assign handle2      = h2_q;
  assign param_bytes  = param_q;

endmodule
